// File: rtl/prog_run_seq.sv
// prog_run_seq: run sequencer for the 9-bit core.
// Takes a program-run request, pulses core_reset, drives the core start
// strobe, then waits for core_done under a cycle watchdog and returns a
// status plus RUN-cycle count.
// Optional feature macro: PROG_RUN_SEQ_RUN_CNT_EN adds a wrapping run counter
// (run_count) and the program select of the last OK run (last_ok_prog).
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// RST   | core_reset held high for RESET_CYCLES cycles
// START | core_start held high for START_HOLD cycles
// RUN   | core executing, counting cycles, watchdog armed
// RESP  | response presented; core parked in reset after TIMEOUT/ABORT
module prog_run_seq #(
  parameter int RESET_CYCLES   = 2,
  parameter int START_HOLD     = 2,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int CW             = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [1:0]    req_prog,
  output logic          req_ready,
  input  logic          abort,
  output logic          core_reset,
  output logic          core_start,
  output logic [1:0]    core_prog_sel,
  input  logic          core_done,
  output logic          resp_valid,
  output logic [1:0]    resp_status,
  input  logic          resp_ready,
  output logic          busy,
  output logic [CW-1:0] cycle_count
`ifdef PROG_RUN_SEQ_RUN_CNT_EN
  ,
  output logic [7:0]    run_count,
  output logic [1:0]    last_ok_prog
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] STA_LAST = CW'(START_HOLD - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] ph_cnt;   // cycles spent in RST / START
  logic [CW-1:0] run_cnt;  // RUN cycle index, saturates at TO_LAST

  // Sequencer FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ph_cnt        <= '0;
      run_cnt       <= '0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
      core_reset    <= 1'b0;
      core_start    <= 1'b0;
      core_prog_sel <= 2'b00;
      resp_valid    <= 1'b0;
      resp_status   <= ST_OK;
      cycle_count   <= '0;
`ifdef PROG_RUN_SEQ_RUN_CNT_EN
      run_count     <= 8'd0;
      last_ok_prog  <= 2'b00;
`endif
    end else if (abort && (state == S_RST || state == S_START || state == S_RUN)) begin
      // Abort wins over done and timeout; run_cnt is still 0 before RUN.
      state       <= S_RESP;
      core_reset  <= 1'b1;
      core_start  <= 1'b0;
      resp_valid  <= 1'b1;
      resp_status <= ST_ABORT;
      cycle_count <= run_cnt;
`ifdef PROG_RUN_SEQ_RUN_CNT_EN
      run_count   <= run_count + 8'd1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            state         <= S_RST;
            core_prog_sel <= req_prog;
            run_cnt       <= '0;
            ph_cnt        <= '0;
            req_ready     <= 1'b0;
            busy          <= 1'b1;
            core_reset    <= 1'b1;
          end
        end
        S_RST: begin
          if (ph_cnt == RST_LAST) begin
            state      <= S_START;
            ph_cnt     <= '0;
            core_reset <= 1'b0;
            core_start <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + CW'(1);
          end
        end
        S_START: begin
          if (ph_cnt == STA_LAST) begin
            state      <= S_RUN;
            ph_cnt     <= '0;
            run_cnt    <= '0;
            core_start <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (core_done) begin
            state       <= S_RESP;
            resp_valid  <= 1'b1;
            resp_status <= ST_OK;
            cycle_count <= run_cnt;
`ifdef PROG_RUN_SEQ_RUN_CNT_EN
            run_count    <= run_count + 8'd1;
            last_ok_prog <= core_prog_sel;
`endif
          end else if (run_cnt == TO_LAST) begin
            state       <= S_RESP;
            core_reset  <= 1'b1;
            resp_valid  <= 1'b1;
            resp_status <= ST_TIMEOUT;
            cycle_count <= TO_LAST;
`ifdef PROG_RUN_SEQ_RUN_CNT_EN
            run_count   <= run_count + 8'd1;
`endif
          end else begin
            run_cnt <= run_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            core_reset <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          core_reset <= 1'b0;
          core_start <= 1'b0;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_run_seq.sv
// Bench for prog_run_seq. Two instances share stimulus: one with default
// parameters and one with TIMEOUT_CYCLES=20. Expected responses are queued
// when a request is issued and popped by a monitor on each handshake.
module tb_prog_run_seq;

  localparam logic [1:0] OK = 2'b00, TO = 2'b01, AB = 2'b10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic [1:0] req_prog = 2'b00;
  logic abort = 1'b0;
  logic core_done = 1'b0;
  logic resp_ready = 1'b0;

  logic a_rr, a_cr, a_cs, a_rv, a_busy;
  logic [1:0] a_ps, a_st;
  logic [11:0] a_cc;
  logic b_rr, b_cr, b_cs, b_rv, b_busy;
  logic [1:0] b_ps, b_st;
  logic [11:0] b_cc;
`ifdef PROG_RUN_SEQ_RUN_CNT_EN
  logic [7:0] a_rc, b_rc;
  logic [1:0] a_lp, b_lp;
`endif

  always #5 clk = ~clk;

  prog_run_seq dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_prog(req_prog),
    .req_ready(a_rr), .abort(abort), .core_reset(a_cr), .core_start(a_cs),
    .core_prog_sel(a_ps), .core_done(core_done), .resp_valid(a_rv),
    .resp_status(a_st), .resp_ready(resp_ready), .busy(a_busy),
    .cycle_count(a_cc)
`ifdef PROG_RUN_SEQ_RUN_CNT_EN
    , .run_count(a_rc), .last_ok_prog(a_lp)
`endif
  );

  prog_run_seq #(.TIMEOUT_CYCLES(20)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_prog(req_prog),
    .req_ready(b_rr), .abort(abort), .core_reset(b_cr), .core_start(b_cs),
    .core_prog_sel(b_ps), .core_done(core_done), .resp_valid(b_rv),
    .resp_status(b_st), .resp_ready(resp_ready), .busy(b_busy),
    .cycle_count(b_cc)
`ifdef PROG_RUN_SEQ_RUN_CNT_EN
    , .run_count(b_rc), .last_ok_prog(b_lp)
`endif
  );

  typedef struct packed {
    logic [1:0]  st;
    logic [11:0] cnt;
    logic [1:0]  prog;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int n_checks = 0;
  int n_errors = 0;

  logic pa_rv = 1'b0, pb_rv = 1'b0, p_rdy = 1'b0;
  logic [1:0] pa_st = 2'b00, pb_st = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sa, input logic [11:0] ca,
                      input logic [1:0] sb, input logic [11:0] cb,
                      input logic [1:0] p);
    qa.push_back({sa, ca, p});
    qb.push_back({sb, cb, p});
  endtask

  // Request accepted at the next edge; afterwards the core is in RST.
  task automatic accept(input logic [1:0] p);
    chk("req_ready_before", a_rr, 1);
    req_valid = 1'b1;
    req_prog  = p;
    tick();
    req_valid = 1'b0;
    chk("accept_core_reset", a_cr, 1);
    chk("accept_core_start", a_cs, 0);
    chk("accept_busy", a_busy, 1);
    chk("accept_req_ready", a_rr, 0);
    chk("accept_prog_sel", a_ps, p);
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 3000 && !a_rv; i++) tick();
    chk("resp_valid_arrives", a_rv, 1);
    chk("resp_valid_b", b_rv, 1);
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("idle_busy", a_busy, 0);
    chk("idle_req_ready", a_rr, 1);
    chk("idle_core_reset", a_cr, 0);
    chk("idle_resp_valid", a_rv, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, {a_rr, b_rr}, 2'b11);
    chk({tag, "_busy"}, {a_busy, b_busy}, 2'b00);
    chk({tag, "_core_reset"}, {a_cr, b_cr}, 2'b00);
    chk({tag, "_core_start"}, {a_cs, b_cs}, 2'b00);
    chk({tag, "_prog_sel"}, {a_ps, b_ps}, 4'd0);
    chk({tag, "_resp_valid"}, {a_rv, b_rv}, 2'b00);
    chk({tag, "_resp_status"}, {a_st, b_st}, 4'd0);
    chk({tag, "_cycle_count"}, {a_cc, b_cc}, 24'd0);
  endtask

  // Response monitor: pops on each handshake and checks backpressure stability.
  always @(negedge clk) begin
    if (!reset) begin
      if (a_rv && resp_ready) begin
        if (qa.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL resp_a_unexpected: got status %0d count %0d expected no response", a_st, a_cc);
        end else begin
          ea = qa.pop_front();
          chk("a_status", a_st, ea.st);
          chk("a_cycle_count", a_cc, ea.cnt);
          chk("a_prog_sel", a_ps, ea.prog);
          chk("a_park_reset", a_cr, ea.st != OK);
        end
      end
      if (b_rv && resp_ready) begin
        if (qb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL resp_b_unexpected: got status %0d count %0d expected no response", b_st, b_cc);
        end else begin
          eb = qb.pop_front();
          chk("b_status", b_st, eb.st);
          chk("b_cycle_count", b_cc, eb.cnt);
          chk("b_prog_sel", b_ps, eb.prog);
          chk("b_park_reset", b_cr, eb.st != OK);
        end
      end
      if (pa_rv && !p_rdy) begin
        chk("a_hold_valid", a_rv, 1);
        chk("a_hold_status", a_st, pa_st);
      end
      if (pb_rv && !p_rdy) begin
        chk("b_hold_valid", b_rv, 1);
        chk("b_hold_status", b_st, pb_st);
      end
    end
    pa_rv <= a_rv;
    pb_rv <= b_rv;
    pa_st <= a_st;
    pb_st <= b_st;
    p_rdy <= resp_ready;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check_reset_state("reset");

    // Normal run, prog 2, done on RUN cycle 37; short-timeout instance times out.
    accept(2);
    push(OK, 12'd37, TO, 12'd19, 2);
    tick();
    chk("rst_hold_2nd", a_cr, 1);
    chk("start_not_yet", a_cs, 0);
    tick();
    chk("rst_released", a_cr, 0);
    chk("start_1st", a_cs, 1);
    tick();
    chk("start_2nd", a_cs, 1);
    chk("prog_sel_mid", a_ps, 2);
    tick();
    chk("start_dropped", a_cs, 0);
    repeat (37) tick();
    pulse_done();
    wait_resp();
    chk("ok_no_park", a_cr, 0);
    take_resp();

    // Timeout: 1999 on default instance, 19 on short instance.
    accept(1);
    push(TO, 12'd1999, TO, 12'd19, 1);
    wait_resp();
    chk("timeout_park", a_cr, 1);
    take_resp();

    // Abort in RUN at counter 5.
    accept(0);
    push(AB, 12'd5, AB, 12'd5, 0);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_park", a_cr, 1);
    wait_resp();
    take_resp();

    // Abort in START.
    accept(1);
    push(AB, 12'd0, AB, 12'd0, 1);
    repeat (2) tick();
    chk("in_start", a_cs, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_start_drop", a_cs, 0);
    wait_resp();
    take_resp();

    // core_done on the timeout cycle of the short instance: OK wins.
    accept(3);
    push(OK, 12'd19, OK, 12'd19, 3);
    repeat (23) tick();
    pulse_done();
    wait_resp();
    take_resp();

    // core_done together with abort: abort wins.
    accept(2);
    push(AB, 12'd8, AB, 12'd8, 2);
    repeat (12) tick();
    abort = 1'b1;
    core_done = 1'b1;
    tick();
    abort = 1'b0;
    core_done = 1'b0;
    wait_resp();
    take_resp();

    // Stray core_done during RST is ignored; done on RUN cycle 3.
    accept(2);
    push(OK, 12'd3, OK, 12'd3, 2);
    pulse_done();
    chk("stray_done_rst", a_cr, 1);
    chk("stray_done_busy", a_busy, 1);
    repeat (6) tick();
    pulse_done();
    wait_resp();
    take_resp();

    // Backpressure for 10 cycles with req_valid pending.
    accept(0);
    push(OK, 12'd2, OK, 12'd2, 0);
    repeat (6) tick();
    pulse_done();
    wait_resp();
    req_valid = 1'b1;
    req_prog  = 2'd3;
    repeat (10) tick();
    chk("bp_valid_after", a_rv, 1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_reentry_ready", a_rr, 1);
    chk("bp_reentry_busy", a_busy, 0);
    tick();
    req_valid = 1'b0;
    chk("bp_accept_ready", a_rr, 0);
    chk("bp_accept_busy", a_busy, 1);
    chk("bp_accept_prog", a_ps, 3);
    chk("bp_accept_core_reset", a_cr, 1);

    // Mid-run reset at RUN cycle 4.
    repeat (8) tick();
    chk("pre_reset_busy", a_busy, 1);
    reset = 1'b1;
    tick();
    check_reset_state("midrun");
    reset = 1'b0;
    tick();

`ifdef PROG_RUN_SEQ_RUN_CNT_EN
    chk("run_count_cleared", a_rc, 0);
    for (int r = 0; r < 3; r++) begin
      accept(r[1:0] + 2'd1);
      push(OK, 12'd0, OK, 12'd0, r[1:0] + 2'd1);
      repeat (4) tick();
      pulse_done();
      wait_resp();
      take_resp();
    end
    chk("run_count_a", a_rc, 3);
    chk("run_count_b", b_rc, 3);
    chk("last_ok_prog", a_lp, 3);
`endif

    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
